// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-read-port integer register file with a
// per-register busy scoreboard for read-after-write hazard detection.
//
// Register 0 is hardwired to zero. Addresses at or above NREGS read as zero
// and are never written. With BYPASS=1 a valid same-cycle write is forwarded
// to every matching read port, and that port's busy flag reads as clear.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous reset, active-low
//   rd_addr   in   NRD*AW    read addresses, port i at [i*AW +: AW]
//   rd_data   out  NRD*XLEN  read data, port i at [i*XLEN +: XLEN]
//   rd_busy   out  NRD       busy flag of each read address
//   wr_en     in   write enable
//   wr_addr   in   AW        write address
//   wr_data   in   XLEN      write data
//   sb_set    in   mark sb_addr as pending (instruction issue)
//   sb_addr   in   AW        destination register for sb_set
//   busy_vec  out  NREGS     registered scoreboard state
module regfile_mp #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NRD*AW-1:0]    rd_addr,
    output logic [NRD*XLEN-1:0]  rd_data,
    output logic [NRD-1:0]       rd_busy,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [XLEN-1:0]      wr_data,
    input  logic                 sb_set,
    input  logic [AW-1:0]        sb_addr,
    output logic [NREGS-1:0]     busy_vec
);

    // Storage spans the full address space so any AW-bit address indexes
    // safely; entries 0 and >= NREGS are never written and stay zero.
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] LIMIT = (AW+1)'(NREGS);

    // Nonzero and within the architectural register count.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (a != '0) && ({1'b0, a} < LIMIT);
    endfunction

    logic [XLEN-1:0]  mem [DEPTH];
    logic [NREGS-1:0] busy;
    logic [DEPTH-1:0] busy_pad;
    logic             wr_ok;
    logic             sb_ok;
    logic [AW-1:0]    ra  [NRD];
    logic             hit [NRD];

    assign wr_ok    = wr_en && addr_ok(wr_addr);
    assign sb_ok    = sb_set && addr_ok(sb_addr);
    assign busy_pad = DEPTH'(busy);
    assign busy_vec = busy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // A set to the register being retired wins: the newly issued producer
    // supersedes the one writing back.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy <= '0;
        end else begin
            busy[0] <= 1'b0;
            for (int r = 1; r < NREGS; r++) begin
                if (sb_ok && (sb_addr == AW'(r))) begin
                    busy[r] <= 1'b1;
                end else if (wr_ok && (wr_addr == AW'(r))) begin
                    busy[r] <= 1'b0;
                end
            end
        end
    end

    // Reads are gated by reset so a forwarded write cannot leak out while
    // the file is held in reset.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int p = 0; p < NRD; p++) begin
            ra[p]  = rd_addr[p*AW +: AW];
            hit[p] = (BYPASS != 0) && wr_ok && (wr_addr == ra[p]);
            if (reset && addr_ok(ra[p])) begin
                if (hit[p]) begin
                    rd_data[p*XLEN +: XLEN] = wr_data;
                    rd_busy[p]              = 1'b0;
                end else begin
                    rd_data[p*XLEN +: XLEN] = mem[ra[p]];
                    rd_busy[p]              = busy_pad[ra[p]];
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: bench for regfile_mp. Three instances share clock, reset,
// write and scoreboard inputs: the default configuration (BYPASS=1), a
// BYPASS=0 copy, and a 24-register, 3-port copy.
module tb_regfile_mp;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        sb_set;
    logic [4:0]  sb_addr;
    logic [9:0]  rd_addr_a;
    logic [14:0] rd_addr_s;

    logic [63:0] rd_data_a, rd_data_n;
    logic [1:0]  rd_busy_a, rd_busy_n;
    logic [31:0] busy_vec_a, busy_vec_n;
    logic [95:0] rd_data_s;
    logic [2:0]  rd_busy_s;
    logic [23:0] busy_vec_s;

    regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(1)) u_dut (
        .clk(clk), .reset(reset), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
        .rd_busy(rd_busy_a), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .sb_set(sb_set), .sb_addr(sb_addr), .busy_vec(busy_vec_a));

    regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(0)) u_nb (
        .clk(clk), .reset(reset), .rd_addr(rd_addr_a), .rd_data(rd_data_n),
        .rd_busy(rd_busy_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .sb_set(sb_set), .sb_addr(sb_addr), .busy_vec(busy_vec_n));

    regfile_mp #(.XLEN(32), .NREGS(24), .NRD(3), .BYPASS(1)) u_sz (
        .clk(clk), .reset(reset), .rd_addr(rd_addr_s), .rd_data(rd_data_s),
        .rd_busy(rd_busy_s), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .sb_set(sb_set), .sb_addr(sb_addr), .busy_vec(busy_vec_s));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic push_exp(input string name, input logic [31:0] val);
        exp_t e;
        e.name = name;
        e.val  = val;
        sbq.push_back(e);
    endtask

    task automatic chk(input logic [31:0] act);
        exp_t e;
        n_checks++;
        if (sbq.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty actual=%h", act);
        end else begin
            e = sbq.pop_front();
            if (act !== e.val) begin
                n_fail++;
                $display("FAIL %s actual=%h required=%h", e.name, act, e.val);
            end
        end
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        ss;
        logic [4:0]  sa;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [1:0]  ab;
        logic [31:0] n0;
        logic [31:0] n1;
        logic [31:0] bv;
    } vec_t;

    vec_t tbl [14];

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Expected values are sampled before the edge that applies the row.
        //            we  wa   wd            ss  sa   ra0 ra1 a0            a1            ab     n0            n1            bv
        tbl[0]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        2'b00, 32'h0,        32'h0,        32'h0};
        tbl[1]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  5'd3,  5'd0,  32'h0,        32'h0,        2'b00, 32'h0,        32'h0,        32'h0};
        tbl[2]  = '{1'b1, 5'd7,  32'h12345678, 1'b0, 5'd0,  5'd7,  5'd7,  32'h12345678, 32'h12345678, 2'b00, 32'h0,        32'h0,        32'h8};
        tbl[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd7,  5'd3,  32'h12345678, 32'h0,        2'b10, 32'h12345678, 32'h0,        32'h8};
        tbl[4]  = '{1'b1, 5'd3,  32'hCAFE0003, 1'b0, 5'd0,  5'd3,  5'd7,  32'hCAFE0003, 32'h12345678, 2'b00, 32'h0,        32'h12345678, 32'h8};
        tbl[5]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd3,  5'd3,  32'hCAFE0003, 32'hCAFE0003, 2'b00, 32'hCAFE0003, 32'hCAFE0003, 32'h0};
        tbl[6]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  5'd9,  5'd0,  32'h0,        32'h0,        2'b00, 32'h0,        32'h0,        32'h0};
        tbl[7]  = '{1'b1, 5'd9,  32'h000000A5, 1'b1, 5'd9,  5'd9,  5'd9,  32'hA5,       32'hA5,       2'b00, 32'h0,        32'h0,        32'h200};
        tbl[8]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd9,  5'd5,  32'hA5,       32'h0,        2'b01, 32'hA5,       32'h0,        32'h200};
        tbl[9]  = '{1'b1, 5'd9,  32'h0000005A, 1'b0, 5'd0,  5'd9,  5'd3,  32'h5A,       32'hCAFE0003, 2'b00, 32'hA5,       32'hCAFE0003, 32'h200};
        tbl[10] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd31, 5'd9,  5'd0,  32'h5A,       32'h0,        2'b00, 32'h5A,       32'h0,        32'h0};
        tbl[11] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd31, 5'd9,  32'h0,        32'h5A,       2'b01, 32'h0,        32'h5A,       32'h80000000};
        tbl[12] = '{1'b1, 5'd31, 32'h1F1F1F1F, 1'b0, 5'd0,  5'd31, 5'd31, 32'h1F1F1F1F, 32'h1F1F1F1F, 2'b00, 32'h0,        32'h0,        32'h80000000};
        tbl[13] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd31, 5'd31, 32'h1F1F1F1F, 32'h1F1F1F1F, 2'b00, 32'h1F1F1F1F, 32'h1F1F1F1F, 32'h0};

        // Held in reset with a write pending: nothing may be visible.
        reset     = 1'b0;
        wr_en     = 1'b1;
        wr_addr   = 5'd5;
        wr_data   = 32'hDEADBEEF;
        sb_set    = 1'b0;
        sb_addr   = 5'd0;
        rd_addr_a = {5'd5, 5'd5};
        rd_addr_s = '0;
        push_exp("reset_rd0", 32'h0);
        push_exp("reset_busy_vec", 32'h0);
        #3;
        chk(rd_data_a[31:0]);
        chk(busy_vec_a);

        // Release between edges; first edge takes the write and the set.
        #9;
        reset   = 1'b1;
        sb_set  = 1'b1;
        sb_addr = 5'd5;
        @(posedge clk);
        #1;
        wr_en  = 1'b0;
        sb_set = 1'b0;
        push_exp("first_write_rd0", 32'hDEADBEEF);
        push_exp("first_write_nb_rd0", 32'hDEADBEEF);
        push_exp("first_set_busy_vec", 32'h20);
        #1;
        chk(rd_data_a[31:0]);
        chk(rd_data_n[31:0]);
        chk(busy_vec_a);

        // Asynchronous reset mid-cycle clears data and scoreboard at once.
        #1;
        reset = 1'b0;
        push_exp("async_reset_rd0", 32'h0);
        push_exp("async_reset_busy_vec", 32'h0);
        push_exp("async_reset_rd_busy", 32'h0);
        #1;
        chk(rd_data_a[31:0]);
        chk(busy_vec_a);
        chk({30'b0, rd_busy_a});

        // An edge while in reset must not apply a write or a set.
        wr_en   = 1'b1;
        wr_addr = 5'd5;
        wr_data = 32'h11111111;
        sb_set  = 1'b1;
        sb_addr = 5'd6;
        @(posedge clk);
        #1;
        push_exp("in_reset_write_rd0", 32'h0);
        push_exp("in_reset_set_busy_vec", 32'h0);
        chk(rd_data_a[31:0]);
        chk(busy_vec_a);
        #2;
        reset  = 1'b1;
        wr_en  = 1'b0;
        sb_set = 1'b0;
        @(posedge clk);
        #1;
        push_exp("post_reset_rd0", 32'h0);
        push_exp("post_reset_busy_vec", 32'h0);
        chk(rd_data_a[31:0]);
        chk(busy_vec_a);

        for (int i = 0; i < 14; i++) begin
            wr_en     = tbl[i].we;
            wr_addr   = tbl[i].wa;
            wr_data   = tbl[i].wd;
            sb_set    = tbl[i].ss;
            sb_addr   = tbl[i].sa;
            rd_addr_a = {tbl[i].ra1, tbl[i].ra0};
            push_exp($sformatf("row%0d_rd0", i), tbl[i].a0);
            push_exp($sformatf("row%0d_rd1", i), tbl[i].a1);
            push_exp($sformatf("row%0d_rd_busy", i), {30'b0, tbl[i].ab});
            push_exp($sformatf("row%0d_nb_rd0", i), tbl[i].n0);
            push_exp($sformatf("row%0d_nb_rd1", i), tbl[i].n1);
            push_exp($sformatf("row%0d_busy_vec", i), tbl[i].bv);
            #4;
            chk(rd_data_a[31:0]);
            chk(rd_data_a[63:32]);
            chk({30'b0, rd_busy_a});
            chk(rd_data_n[31:0]);
            chk(rd_data_n[63:32]);
            chk(busy_vec_a);
            @(posedge clk);
            #1;
        end

        // 24-register copy: writes and sets to r31 were out of range there.
        wr_en     = 1'b0;
        sb_set    = 1'b0;
        rd_addr_s = {5'd3, 5'd7, 5'd9};
        push_exp("sz_rd0_r9", 32'h5A);
        push_exp("sz_rd1_r7", 32'h12345678);
        push_exp("sz_rd2_r3", 32'hCAFE0003);
        push_exp("sz_busy_vec", 32'h0);
        #4;
        chk(rd_data_s[31:0]);
        chk(rd_data_s[63:32]);
        chk(rd_data_s[95:64]);
        chk({8'b0, busy_vec_s});

        rd_addr_s = {5'd9, 5'd31, 5'd30};
        push_exp("sz_rd0_r30", 32'h0);
        push_exp("sz_rd1_r31", 32'h0);
        push_exp("sz_rd2_r9", 32'h5A);
        #1;
        chk(rd_data_s[31:0]);
        chk(rd_data_s[63:32]);
        chk(rd_data_s[95:64]);

        // Write and set to r30: in range for 32 registers, ignored for 24.
        @(posedge clk);
        #1;
        wr_en     = 1'b1;
        wr_addr   = 5'd30;
        wr_data   = 32'hEEEEEEEE;
        sb_set    = 1'b1;
        sb_addr   = 5'd30;
        rd_addr_a = {5'd30, 5'd30};
        push_exp("sz_oor_bypass_rd0", 32'h0);
        push_exp("sz_oor_rd_busy", 32'h0);
        #4;
        chk(rd_data_s[31:0]);
        chk({29'b0, rd_busy_s});
        @(posedge clk);
        #1;
        wr_en  = 1'b0;
        sb_set = 1'b0;
        push_exp("sz_oor_after_rd0", 32'h0);
        push_exp("sz_oor_after_busy_vec", 32'h0);
        push_exp("r30_after_rd1", 32'hEEEEEEEE);
        push_exp("r30_set_busy_vec", 32'h40000000);
        push_exp("r30_rd_busy", 32'h3);
        #4;
        chk(rd_data_s[31:0]);
        chk({8'b0, busy_vec_s});
        chk(rd_data_a[63:32]);
        chk(busy_vec_a);
        chk({30'b0, rd_busy_a});

        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_leftover actual=%0d required=0", sbq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port integer register file for the single-cycle core and its planned pipelined successor.
- Provides NRD combinational read ports, one synchronous write port, a hardwired-zero register 0, and an optional write-to-read bypass.
- Includes a per-register busy scoreboard. Issue logic sets a destination's busy bit; the writeback that retires it clears the bit. The pipeline uses this to detect read-after-write hazards.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers (2..64). Localparam AW = $clog2(NREGS).
- NRD, 2, number of read ports (1..4).
- BYPASS, 1: when 1, same-cycle write data is forwarded to matching read ports and clears their busy flag; when 0, no forwarding.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous reset, active-low (0 = reset asserted).
- rd_addr  in  NRD*AW  read addresses; port i uses bits [i*AW +: AW].
- rd_data  out  NRD*XLEN  read data; port i uses bits [i*XLEN +: XLEN].
- rd_busy  out  NRD  busy flag for each read address.
- wr_en  in  1  write enable.
- wr_addr  in  AW  write address.
- wr_data  in  XLEN  write data.
- sb_set  in  1  mark a destination as pending (instruction issue).
- sb_addr  in  AW  destination register for sb_set.
- busy_vec  out  NREGS  full scoreboard state, registered.

Behaviour:
Reset
- reset=0 asynchronously clears all registers to 0 and all busy bits to 0, regardless of clk.
- While reset=0: rd_data=0 on all ports, rd_busy=0, busy_vec=0.
- The first write takes effect on the first rising edge with reset=1.
- Reset asserted mid-operation discards any in-flight write and any scoreboard set.

Write
- Occurs at the rising edge when wr_en=1, wr_addr!=0 and wr_addr<NREGS.
- All other writes are ignored: no state change, no bypass.
- Register 0 has no storage and always reads 0.

Read
- Purely combinational, zero latency.
- Address 0 or address >=NREGS returns 0.
- If BYPASS=1 and port i matches a valid write this cycle (wr_en=1, wr_addr=rd_addr_i, address nonzero and in range): rd_data_i=wr_data.
- Otherwise rd_data_i is the stored value. With BYPASS=0 the new value is visible from the next cycle.
- All ports are independent. Identical addresses on several ports return identical data.

Scoreboard (rising edge)
- For each r in 1..NREGS-1, next busy[r] is:
  - 1 if sb_set=1 and sb_addr=r;
  - else 0 if a valid write targets r;
  - else unchanged.
- Simultaneous set and write to the same register: set wins, because the new producer supersedes the retiring one.
- Simultaneous set and write to different registers: both take effect.
- busy[0] is always 0. sb_set to address 0 or out-of-range is ignored.
- Setting an already-busy register leaves it busy. The scoreboard has no counting or multiple-outstanding tracking.

rd_busy
- rd_busy_i = busy[rd_addr_i].
- If BYPASS=1 and a valid write matches rd_addr_i this cycle, rd_busy_i=0 (the data is being forwarded).
- The sb_set of the current cycle does not affect rd_busy in the same cycle.

General
- No X propagation: all outputs are defined for any input combination once reset is released.

Test Plan:
- Reset: write 0xDEADBEEF to r5, then pulse reset=0 between clock edges → rd_data for r5 reads 0 immediately; busy_vec=0 with no clock edge.
- Register 0: wr_en=1, wr_addr=0, wr_data=0xFFFFFFFF; sb_set to 0 → reads of r0 return 0 on every port; busy_vec[0]=0; bypass does not fire.
- Bypass (BYPASS=1): rd_addr0=rd_addr1=7, write 0x12345678 to r7 in the same cycle → both ports show 0x12345678 before the edge. Repeat with BYPASS=0 → old value until after the edge, then 0x12345678.
- Scoreboard: sb_set r3 at cycle 1 → busy_vec[3]=1 from cycle 2. Write r3 at cycle 4 → rd_busy=0 during cycle 4 (BYPASS=1) and busy_vec[3]=0 from cycle 5.
- Set/clear collision: r9 busy; in the same cycle sb_set r9 and write r9=0xA5 → next cycle busy[9]=1 and r9 reads 0xA5.
- Sizing: NREGS=24, NRD=3, read address 30 → reads 0; write to 30 changes no state; all three ports read distinct registers correctly.
